// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Round-robin arbiter that shares a dual-channel event counter between N
//   requesters. The current owner drives the counter's En/Slt pins and gets
//   one increment per cycle while it holds Req. When other requesters are
//   waiting, a burst limit moves the grant on after BURST increments.
//
// Ports
//   Clk      in   1   clock, all state updates on posedge
//   Reset_n  in   1   asynchronous active-low reset
//   Req      in   N   Req[i]=1: requester i wants one increment per cycle
//   ReqSlt   in   N   channel select of requester i (0=channel 0, 1=channel 1)
//   Grant    out  N   registered one-hot owner, all-zero when idle
//   Owner    out  W   registered index of the current owner (0 when idle)
//   Busy     out  1   registered, 1 while a requester owns the counter
//   En       out  1   counter enable: Busy & Req[Owner]
//   Slt      out  1   counter channel select: ReqSlt[Owner] when En=1, else 0
module counter_arbiter #(
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [N-1:0]         Req,
    input  logic [N-1:0]         ReqSlt,
    output logic [N-1:0]         Grant,
    output logic [$clog2(N)-1:0] Owner,
    output logic                 Busy,
    output logic                 En,
    output logic                 Slt
);

    localparam int W  = $clog2(N);
    localparam int CW = $clog2(BURST + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0]    state, state_d;
    logic [W-1:0]  owner_d;
    logic [W-1:0]  last, last_d;
    logic [CW-1:0] burst_cnt, burst_d;
    logic [N-1:0]  grant_d;

    // Scan base+1, base+2, ... (mod N) for the first active request,
    // optionally skipping one index. Returns {found, index}.
    function automatic logic [W:0] pick(
        input logic [N-1:0] req,
        input logic [W-1:0] base,
        input logic         excl_en,
        input logic [W-1:0] excl
    );
        logic         found;
        logic [W-1:0] sel;
        logic [W-1:0] p;
        int unsigned  pos;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = (32'(base) + k) % N;
            p   = W'(pos);
            if (!found && req[p] && !(excl_en && (p == excl))) begin
                found = 1'b1;
                sel   = p;
            end
        end
        return {found, sel};
    endfunction

    logic [W:0] pick_idle;
    logic [W:0] pick_next;
    logic       others;

    always_comb begin
        pick_idle = pick(Req, last, 1'b0, '0);
        // Scanning from the owner is the same as scanning from the updated
        // last pointer, since every hand-over also sets last to the owner.
        pick_next = pick(Req, Owner, 1'b1, Owner);
        others    = |(Req & ~Grant);
    end

    always_comb begin
        state_d = state;
        owner_d = Owner;
        last_d  = last;
        burst_d = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_idle[W]) begin
                    state_d = OWN;
                    owner_d = pick_idle[W-1:0];
                    burst_d = '0;
                end
            end
            default: begin
                if (!Req[Owner]) begin
                    last_d  = Owner;
                    burst_d = '0;
                    if (others) begin
                        owner_d = pick_next[W-1:0];
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end else if ((burst_cnt == CW'(BURST - 1)) && others) begin
                    last_d  = Owner;
                    owner_d = pick_next[W-1:0];
                    burst_d = '0;
                end else if (burst_cnt != CW'(BURST - 1)) begin
                    burst_d = burst_cnt + CW'(1);
                end
            end
        endcase
        grant_d = '0;
        if (state_d == OWN) begin
            grant_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Owner     <= '0;
            last      <= W'(N - 1);
            burst_cnt <= '0;
            Grant     <= '0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_d;
            Owner     <= owner_d;
            last      <= last_d;
            burst_cnt <= burst_d;
            Grant     <= grant_d;
            Busy      <= (state_d == OWN);
        end
    end

    always_comb begin
        En  = Busy & Req[Owner];
        Slt = En & ReqSlt[Owner];
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter
//   Directed bench for counter_arbiter: a 4-requester instance for most
//   scenarios and a 3-requester instance for the non-power-of-2 wrap case.
//   Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_counter_arbiter;

    logic       Clk;
    logic       Reset_n;
    logic [3:0] Req, ReqSlt, Grant;
    logic [1:0] Owner;
    logic       Busy, En, Slt;
    logic [2:0] Req3, ReqSlt3, Grant3;
    logic [1:0] Owner3;
    logic       Busy3, En3, Slt3;

    int checks = 0;
    int errors = 0;

    counter_arbiter #(.N(4), .BURST(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .ReqSlt(ReqSlt),
        .Grant(Grant), .Owner(Owner), .Busy(Busy), .En(En), .Slt(Slt)
    );

    counter_arbiter #(.N(3), .BURST(4)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req3), .ReqSlt(ReqSlt3),
        .Grant(Grant3), .Owner(Owner3), .Busy(Busy3), .En(En3), .Slt(Slt3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Applies reset for one cycle; returns at the falling edge after release.
    task automatic do_reset();
        @(negedge Clk);
        Req = '0; ReqSlt = '0; Req3 = '0; ReqSlt3 = '0;
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        Req = 4'b1111; ReqSlt = 4'b1111;
        @(negedge Clk);
        #1;
        checks++;
        if ({Grant, Owner, Busy, En, Slt} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b owner=%0d busy=%b en=%b slt=%b expected all 0",
                     Grant, Owner, Busy, En, Slt);
        end
        Req = '0; ReqSlt = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_single();
        int en_cnt = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            Req = 4'b0001; ReqSlt = 4'b0000;
            #1;
            checks++;
            if (Grant !== ((c == 0) ? 4'b0000 : 4'b0001)) begin
                errors++;
                $display("FAIL single_grant cycle %0d got %b expected %b", c, Grant,
                         (c == 0) ? 4'b0000 : 4'b0001);
            end
            checks++;
            if (Busy !== (c != 0) || Slt !== 1'b0) begin
                errors++;
                $display("FAIL single_busy_slt cycle %0d got busy=%b slt=%b expected busy=%b slt=0",
                         c, Busy, Slt, (c != 0));
            end
            if (En === 1'b1) en_cnt++;
            @(negedge Clk);
        end
        checks++;
        if (en_cnt != 5) begin
            errors++;
            $display("FAIL single_en_count got %0d expected 5", en_cnt);
        end
        Req = '0;
        #1;
        checks++;
        if (En !== 1'b0) begin
            errors++;
            $display("FAIL single_drop_en got %b expected 0", En);
        end
        @(negedge Clk);
    endtask

    task automatic test_burst_rotation();
        logic [1:0] seq [4];
        logic [1:0] exp_o;
        logic [3:0] exp_g;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3; seq[3] = 2'd0;
        do_reset();
        Req = 4'b1011;
        #1;
        checks++;
        if (Grant !== 4'b0000) begin
            errors++;
            $display("FAIL burst_latency got %b expected 0000", Grant);
        end
        @(negedge Clk);
        for (int j = 0; j < 16; j++) begin
            #1;
            exp_o = seq[j / 4];
            exp_g = 4'b0001 << exp_o;
            checks++;
            if (Owner !== exp_o || Grant !== exp_g || En !== 1'b1) begin
                errors++;
                $display("FAIL burst_owner step %0d got owner=%0d grant=%b en=%b expected owner=%0d grant=%b en=1",
                         j, Owner, Grant, En, exp_o, exp_g);
            end
            @(negedge Clk);
        end
        Req = '0;
        @(negedge Clk);
        #1;
        checks++;
        if (Busy !== 1'b0 || Grant !== 4'b0000) begin
            errors++;
            $display("FAIL burst_idle got busy=%b grant=%b expected 0/0000", Busy, Grant);
        end
    endtask

    task automatic test_release();
        do_reset();
        Req = 4'b0110;
        #1;
        checks++;
        if (Grant !== 4'b0000) begin
            errors++;
            $display("FAIL release_latency got %b expected 0000", Grant);
        end
        @(negedge Clk);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (Owner !== 2'd1 || En !== 1'b1) begin
                errors++;
                $display("FAIL release_owner1 step %0d got owner=%0d en=%b expected 1/1", k, Owner, En);
            end
            @(negedge Clk);
        end
        Req = 4'b0100;
        #1;
        checks++;
        if (En !== 1'b0 || Grant !== 4'b0010) begin
            errors++;
            $display("FAIL release_cycle got en=%b grant=%b expected 0/0010", En, Grant);
        end
        @(negedge Clk);
        #1;
        checks++;
        if (Grant !== 4'b0100 || En !== 1'b1) begin
            errors++;
            $display("FAIL release_handover got grant=%b en=%b expected 0100/1", Grant, En);
        end
        @(negedge Clk);
        Req = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (Owner !== 2'd2 || En !== 1'b1) begin
                errors++;
                $display("FAIL release_burst_restart step %0d got owner=%0d en=%b expected 2/1", k, Owner, En);
            end
            @(negedge Clk);
        end
        #1;
        checks++;
        if (Owner !== 2'd1 || Grant !== 4'b0010 || En !== 1'b1) begin
            errors++;
            $display("FAIL release_rotate got owner=%0d grant=%b en=%b expected 1/0010/1", Owner, Grant, En);
        end
        Req = '0;
        @(negedge Clk);
    endtask

    task automatic test_slt_switch();
        logic slt_seq [3];
        int ch0 = 0;
        int ch1 = 0;
        slt_seq[0] = 1'b0; slt_seq[1] = 1'b1; slt_seq[2] = 1'b0;
        do_reset();
        Req = 4'b0001; ReqSlt = 4'b0001;
        #1;
        checks++;
        if (Slt !== 1'b0) begin
            errors++;
            $display("FAIL slt_without_en got %b expected 0", Slt);
        end
        @(negedge Clk);
        for (int k = 0; k < 3; k++) begin
            ReqSlt = {3'b000, slt_seq[k]};
            #1;
            checks++;
            if (En !== 1'b1 || Slt !== slt_seq[k]) begin
                errors++;
                $display("FAIL slt_follow step %0d got en=%b slt=%b expected 1/%b", k, En, Slt, slt_seq[k]);
            end
            if (En === 1'b1 && Slt === 1'b0) ch0++;
            if (En === 1'b1 && Slt === 1'b1) ch1++;
            @(negedge Clk);
        end
        checks++;
        if (ch0 != 2 || ch1 != 1) begin
            errors++;
            $display("FAIL slt_counts got ch0=%0d ch1=%0d expected 2/1", ch0, ch1);
        end
        Req = '0; ReqSlt = '0;
        @(negedge Clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        Req = 4'b1111; ReqSlt = 4'b1111;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        checks++;
        if (En !== 1'b1 || Owner !== 2'd0) begin
            errors++;
            $display("FAIL async_pre got en=%b owner=%0d expected 1/0", En, Owner);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (En !== 1'b0 || Grant !== 4'b0000 || Busy !== 1'b0 || Slt !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got en=%b grant=%b busy=%b slt=%b expected 0/0000/0/0",
                     En, Grant, Busy, Slt);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        checks++;
        if (Grant !== 4'b0000) begin
            errors++;
            $display("FAIL async_latency got %b expected 0000", Grant);
        end
        @(negedge Clk);
        #1;
        checks++;
        if (Grant !== 4'b0001 || Owner !== 2'd0) begin
            errors++;
            $display("FAIL async_first_owner got grant=%b owner=%0d expected 0001/0", Grant, Owner);
        end
        Req = '0; ReqSlt = '0;
        @(negedge Clk);
    endtask

    task automatic test_n3_wrap();
        int en_cnt = 0;
        logic [1:0] exp_o;
        do_reset();
        Req3 = 3'b111;
        #1;
        checks++;
        if (Grant3 !== 3'b000) begin
            errors++;
            $display("FAIL n3_latency got %b expected 000", Grant3);
        end
        @(negedge Clk);
        for (int j = 0; j < 39; j++) begin
            #1;
            exp_o = 2'((j / 4) % 3);
            checks++;
            if (Owner3 !== exp_o || En3 !== 1'b1) begin
                errors++;
                $display("FAIL n3_owner step %0d got owner=%0d en=%b expected %0d/1", j, Owner3, En3, exp_o);
            end
            if (En3 === 1'b1) en_cnt++;
            @(negedge Clk);
        end
        checks++;
        if (en_cnt != 39) begin
            errors++;
            $display("FAIL n3_en_count got %0d expected 39", en_cnt);
        end
        Req3 = '0;
        @(negedge Clk);
    endtask

    initial begin
        Reset_n = 1'b0;
        Req = '0; ReqSlt = '0; Req3 = '0; ReqSlt3 = '0;
        test_reset();
        test_single();
        test_burst_rotation();
        test_release();
        test_slt_switch();
        test_async_reset();
        test_n3_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
